move_input_encoder: RTL and testbench
=====================================

Name: move_input_encoder

Overview:
- Input-side counterpart of the board-to-pin output path: turns a raw push-button plus four column switches into a validated, handshaked move request for the game logic.
- Synchronises and debounces the button, and samples the one-hot column switches on a confirmed press.
- Checks the selected column against the per-column fill counters and the game-over flag.
- Offers {column, landing row} to the column selector and FSM over a valid/ready handshake, or pulses a coded reject.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high (or low) cycles needed to confirm a press (or release); legal range 2..65535.
- NUM_COLS, 4: board columns; equals the switch width.
- NUM_ROWS, 4: board rows; a column with count >= NUM_ROWS is full.
- CNT_W, 3: width of each per-column fill counter.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- btn_raw  input  1  raw push-button (BTN_EAST), asynchronous to clk.
- sw  input  NUM_COLS  column select switches, expected one-hot, quasi-static.
- col_counts  input  NUM_COLS*CNT_W  fill count per column; column c occupies [c*CNT_W +: CNT_W].
- game_over  input  1  high when the game is won or drawn.
- move_ready  input  1  consumer accepts the offered move.
- move_valid  output  1  move offer is present.
- move_col  output  2  selected column index, binary.
- move_row  output  2  landing row, equal to the fill count of the selected column.
- reject  output  1  one-cycle pulse when a press is refused.
- reject_code  output  2  01 = switches not one-hot, 10 = column full, 11 = game over; held until the next reject.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; synchroniser flops, debounce counter and all outputs go to 0.
  - Reset deasserts synchronously to clk (the top-level reset is already synchronised).
  - Reset mid-offer drops move_valid immediately; the move is not retried.
- Synchronisation: btn_raw passes through two flops to give btn_s; only btn_s is used.
- FSM states and transitions:
  - IDLE: if btn_s=1, load cnt=1 and go to PRESS_DB.
  - PRESS_DB:
    - btn_s=0 clears cnt and returns to IDLE (glitch).
    - Otherwise cnt increments.
    - When cnt==DEBOUNCE_CYCLES, register sw and the selected column's count, then go to VALIDATE.
  - VALIDATE (exactly one cycle), checks in priority order:
    - game_over=1 -> reject with code 11.
    - sw not exactly one-hot (zero or multiple bits set) -> reject with code 01.
    - Selected count >= NUM_ROWS -> reject with code 10.
    - Any reject: pulse reject and go to RELEASE_DB.
    - Otherwise load move_col (encoded) and move_row, assert move_valid, go to OFFER.
  - OFFER:
    - move_valid, move_col and move_row are held stable until the cycle in which move_ready=1.
    - Leave on that same edge: move_valid=0, go to RELEASE_DB.
    - The press is already confirmed, so btn_s, sw, col_counts and game_over changes are ignored here.
  - RELEASE_DB:
    - Count consecutive btn_s=0 cycles; any btn_s=1 restarts the count.
    - After DEBOUNCE_CYCLES zeros, go to IDLE.
    - A held button never produces a second move.
- Latency:
  - A clean btn_raw rising edge sampled at edge 0 gives move_valid high after edge DEBOUNCE_CYCLES+3.
  - move_ready already high at that point completes the handshake on the next edge, so move_valid is high for exactly one cycle.
- Width rules:
  - move_row takes the low 2 bits of the captured count; the full check uses all CNT_W bits.
  - move_col is the index of the single set sw bit.
- Simultaneous events:
  - Button bounce during PRESS_DB restarts from IDLE.
  - A reject pulse and move_valid are never high in the same cycle.

Decomposition:
- Shared package, consumed by this block and the game FSM:
  - State encoding localparams: IDLE=0, PRESS_DB=1, VALIDATE=2, OFFER=3, RELEASE_DB=4.
  - Reject code constants: REJ_ONEHOT=2'b01, REJ_FULL=2'b10, REJ_OVER=2'b11.
  - Board dimension constants.
- Sub-module btn_sync_debounce: two-flop synchroniser plus a saturating counter with level and rise/fall-confirmed outputs. Reusable by the reset and switch paths.

Test Plan:
- Clean press: sw=0100, col_counts col2=1, move_ready tied 1, button held 20 cycles -> move_valid high one cycle at DEBOUNCE_CYCLES+3, move_col=2, move_row=1, no reject.
- Bounce: btn_raw toggles 1,0,1,0 each cycle, then stays high -> exactly one move; no move during the toggling.
- Backpressure: move_ready=0 for 10 cycles after move_valid; change sw and col_counts during the wait -> col and row stay at their captured values; handshake on the first move_ready=1; move_valid drops on the next edge.
- Rejects, one press each:
  - sw=0110 -> reject pulse, code 01.
  - sw=0001 with col0 count=4 -> code 10.
  - game_over=1 -> code 11.
  - No move_valid in any of these cases.
- Held button: button held 200 cycles after a handshake -> exactly one move; after release plus DEBOUNCE_CYCLES, a second press yields a second move.
- Reset mid-offer: assert reset while move_valid=1 -> move_valid and busy drop within the same cycle; after deassert, state is IDLE and a new press works.

Source files
------------

// File: rtl/move_input_encoder_pkg.sv
// Shared definitions for the move input path and the game FSM.
// Contents: FSM state encoding, reject codes and the default board dimensions.
package move_input_encoder_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    VALIDATE   = 3'd2,
    OFFER      = 3'd3,
    RELEASE_DB = 3'd4
  } state_e;

  localparam logic [1:0] REJ_ONEHOT = 2'b01;
  localparam logic [1:0] REJ_FULL   = 2'b10;
  localparam logic [1:0] REJ_OVER   = 2'b11;

  localparam int BOARD_COLS       = 4;
  localparam int BOARD_ROWS       = 4;
  localparam int BOARD_CNT_W      = 3;
  localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchroniser plus a saturating run counter for a single asynchronous input.
// The owner picks the level to confirm (track); rise_ok/fall_ok fire once that level has held DEBOUNCE_CYCLES.
module btn_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic track,
  input  logic hold,
  input  logic rearm,
  output logic level,
  output logic rise_ok,
  output logic fall_ok
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] base;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
    end
  end

  // rearm counts from zero this cycle; hold parks the counter at zero.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
    cnt_d = '0;
    base  = rearm ? '0 : cnt_q;
    if (!hold && (sync_q == track)) begin
      cnt_d = (base == CNT_MAX) ? CNT_MAX : base + CW'(1);
    end
  end

  assign level   = sync_q;
  assign rise_ok = track && (cnt_q == CNT_MAX);
  assign fall_ok = !track && (cnt_q == CNT_MAX);

endmodule

// File: rtl/move_input_encoder.sv
// Turns a bouncy push-button and one-hot column switches into a validated move offer
// (valid/ready) for the game logic, or a coded one-cycle reject pulse.
module move_input_encoder
  import move_input_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int NUM_COLS        = BOARD_COLS,
  parameter int NUM_ROWS        = BOARD_ROWS,
  parameter int CNT_W           = BOARD_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn_raw,
  input  logic [NUM_COLS-1:0]       sw,
  input  logic [NUM_COLS*CNT_W-1:0] col_counts,
  input  logic                      game_over,
  input  logic                      move_ready,
  output logic                      move_valid,
  output logic [1:0]                move_col,
  output logic [1:0]                move_row,
  output logic                      reject,
  output logic [1:0]                reject_code,
  output logic                      busy
);

  state_e             state_q;
  state_e             state_d;
  logic               btn_s;
  logic               rise_ok;
  logic               fall_ok;
  logic               db_track;
  logic               db_hold;
  logic               db_rearm;
  logic [NUM_COLS-1:0] sw_q;
  logic [NUM_COLS-1:0] sw_d;
  logic [CNT_W-1:0]   sel_cnt_q;
  logic [CNT_W-1:0]   sel_cnt_d;
  logic [CNT_W-1:0]   live_cnt;
  logic               move_valid_d;
  logic [1:0]         move_col_d;
  logic [1:0]         move_row_d;
  logic               reject_d;
  logic [1:0]         reject_code_d;

  // Lowest set bit wins; only meaningful once the one-hot check has passed.
  function automatic logic [1:0] col_index(input logic [NUM_COLS-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (v[c]) idx = 2'(c);
    end
    return idx;
  endfunction

  btn_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (reset),
    .raw    (btn_raw),
    .track  (db_track),
    .hold   (db_hold),
    .rearm  (db_rearm),
    .level  (btn_s),
    .rise_ok(rise_ok),
    .fall_ok(fall_ok)
  );

  always_comb begin
    live_cnt = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_index(sw) == 2'(c)) live_cnt = col_counts[c*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sw_q        <= '0;
      sel_cnt_q   <= '0;
      move_valid  <= 1'b0;
      move_col    <= 2'd0;
      move_row    <= 2'd0;
      reject      <= 1'b0;
      reject_code <= 2'd0;
    end else begin
      state_q     <= state_d;
      sw_q        <= sw_d;
      sel_cnt_q   <= sel_cnt_d;
      move_valid  <= move_valid_d;
      move_col    <= move_col_d;
      move_row    <= move_row_d;
      reject      <= reject_d;
      reject_code <= reject_code_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sw_d          = sw_q;
    sel_cnt_d     = sel_cnt_q;
    move_valid_d  = move_valid;
    move_col_d    = move_col;
    move_row_d    = move_row;
    reject_d      = 1'b0;
    reject_code_d = reject_code;
    db_track      = 1'b1;
    db_hold       = 1'b0;
    db_rearm      = 1'b0;

    unique case (state_q)
      IDLE: begin
        db_rearm = 1'b1;
        if (btn_s) state_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (rise_ok) begin
          sw_d      = sw;
          sel_cnt_d = live_cnt;
          state_d   = VALIDATE;
        end
      end
      VALIDATE: begin
        db_hold = 1'b1;
        state_d = RELEASE_DB;
        if (game_over) begin
          reject_d      = 1'b1;
          reject_code_d = REJ_OVER;
        end else if ($countones(sw_q) != 1) begin
          reject_d      = 1'b1;
          reject_code_d = REJ_ONEHOT;
        end else if (int'(sel_cnt_q) >= NUM_ROWS) begin
          reject_d      = 1'b1;
          reject_code_d = REJ_FULL;
        end else begin
          move_valid_d = 1'b1;
          move_col_d   = col_index(sw_q);
          move_row_d   = sel_cnt_q[1:0];
          state_d      = OFFER;
        end
      end
      OFFER: begin
        // The press is already confirmed; only the consumer can end the offer.
        db_hold = 1'b1;
        if (move_ready) begin
          move_valid_d = 1'b0;
          state_d      = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        db_track = 1'b0;
        if (fall_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_move_input_encoder.sv
// Directed bench for move_input_encoder: a scoreboard queue holds the expected move or
// reject for each press and a negedge monitor pops and compares whatever the DUT emits.
module tb_move_input_encoder;

  localparam int D  = 4;
  localparam int NC = 4;
  localparam int NR = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            btn_raw = 1'b0;
  logic [NC-1:0]   sw = '0;
  logic [NC*CW-1:0] col_counts = '0;
  logic            game_over = 1'b0;
  logic            move_ready = 1'b0;
  logic            move_valid;
  logic [1:0]      move_col;
  logic [1:0]      move_row;
  logic            reject;
  logic [1:0]      reject_code;
  logic            busy;

  int tests = 0;
  int fails = 0;
  int n_moves = 0;
  int n_rejects = 0;

  typedef struct {
    logic       is_rej;
    logic [1:0] col;
    logic [1:0] row;
    logic [1:0] code;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic       prev_stall = 1'b0;
  logic [1:0] prev_col = 2'd0;
  logic [1:0] prev_row = 2'd0;

  always #5 clk = ~clk;

  move_input_encoder #(
    .DEBOUNCE_CYCLES(D),
    .NUM_COLS       (NC),
    .NUM_ROWS       (NR),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .sw         (sw),
    .col_counts (col_counts),
    .game_over  (game_over),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_col   (move_col),
    .move_row   (move_row),
    .reject     (reject),
    .reject_code(reject_code),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NC*CW-1:0] cc(input int c0, input int c1, input int c2, input int c3);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  // Inputs change 1 time unit after the active edge, well clear of sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) step();
    check("idle_within_budget", {31'b0, busy}, 0);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !move_valid; i++) step();
    check("valid_within_budget", {31'b0, move_valid}, 1);
  endtask

  task automatic run_case(input string tag, input logic [3:0] s, input logic [NC*CW-1:0] cnts,
                          input logic go, input logic is_rej, input logic [1:0] code,
                          input logic [1:0] col, input logic [1:0] row);
    int m0;
    int r0;
    m0 = n_moves;
    r0 = n_rejects;
    sw = s;
    col_counts = cnts;
    game_over = go;
    move_ready = 1'b1;
    sb.push_back('{is_rej, col, row, code});
    btn_raw = 1'b1;
    repeat (20) step();
    btn_raw = 1'b0;
    wait_idle(100);
    check({tag, "_moves"}, n_moves - m0, is_rej ? 0 : 1);
    check({tag, "_rejects"}, n_rejects - r0, is_rej ? 1 : 0);
    if (is_rej) check({tag, "_code_held"}, {30'b0, reject_code}, {30'b0, code});
    game_over = 1'b0;
  endtask

  // Scoreboard monitor: every handshake or reject pulse consumes one expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (move_valid || reject) check("valid_reject_exclusive", {31'b0, move_valid & reject}, 0);
      if (prev_stall) begin
        check("stall_valid", {31'b0, move_valid}, 1);
        check("stall_col", {30'b0, move_col}, {30'b0, prev_col});
        check("stall_row", {30'b0, move_row}, {30'b0, prev_row});
      end
      if ((move_valid && move_ready) || reject) begin
        check("sb_has_entry", {31'b0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          if (reject) begin
            n_rejects++;
            check("kind_reject", {31'b0, e.is_rej}, 1);
            check("reject_code", {30'b0, reject_code}, {30'b0, e.code});
          end else begin
            n_moves++;
            check("kind_move", {31'b0, e.is_rej}, 0);
            check("move_col", {30'b0, move_col}, {30'b0, e.col});
            check("move_row", {30'b0, move_row}, {30'b0, e.row});
          end
        end
      end
      prev_stall = move_valid && !move_ready;
      prev_col   = move_col;
      prev_row   = move_row;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m0;
    int r0;

    // Reset state
    repeat (3) step();
    check("rst_valid", {31'b0, move_valid}, 0);
    check("rst_reject", {31'b0, reject}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_code", {30'b0, reject_code}, 0);
    check("rst_col_row", {28'b0, move_col, move_row}, 0);
    reset = 1'b1;
    step();

    // Clean press: move_valid exactly after edge D+3, one cycle wide
    sw = 4'b0100;
    col_counts = cc(0, 0, 1, 0);
    move_ready = 1'b1;
    m0 = n_moves;
    r0 = n_rejects;
    sb.push_back('{1'b0, 2'd2, 2'd1, 2'd0});
    btn_raw = 1'b1;
    for (int k = 0; k <= D + 4; k++) begin
      step();
      check($sformatf("latency_edge%0d", k), {31'b0, move_valid}, (k == D + 3) ? 1 : 0);
    end
    repeat (20 - (D + 5)) step();
    btn_raw = 1'b0;
    wait_idle(100);
    check("clean_moves", n_moves - m0, 1);
    check("clean_rejects", n_rejects - r0, 0);

    // Bounce: 1,0,1,0 then steady high gives exactly one move
    sw = 4'b0010;
    col_counts = cc(0, 2, 0, 0);
    m0 = n_moves;
    sb.push_back('{1'b0, 2'd1, 2'd2, 2'd0});
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0);
      step();
    end
    btn_raw = 1'b1;
    repeat (3) step();
    check("bounce_no_early_move", n_moves - m0, 0);
    check("bounce_no_early_valid", {31'b0, move_valid}, 0);
    repeat (20) step();
    btn_raw = 1'b0;
    wait_idle(100);
    check("bounce_one_move", n_moves - m0, 1);

    // Backpressure: captured col/row survive input changes until move_ready
    sw = 4'b1000;
    col_counts = cc(0, 0, 0, 2);
    move_ready = 1'b0;
    sb.push_back('{1'b0, 2'd3, 2'd2, 2'd0});
    btn_raw = 1'b1;
    wait_valid(30);
    for (int i = 0; i < 10; i++) begin
      sw = 4'($urandom_range(0, 15));
      col_counts = 12'($urandom);
      game_over = 1'($urandom_range(0, 1));
      step();
      check("bp_valid", {31'b0, move_valid}, 1);
      check("bp_col_row", {28'b0, move_col, move_row}, {28'b0, 2'd3, 2'd2});
    end
    game_over = 1'b0;
    move_ready = 1'b1;
    step();
    check("bp_valid_drop", {31'b0, move_valid}, 0);
    btn_raw = 1'b0;
    wait_idle(100);

    // Rejects, boundaries and check priority
    run_case("onehot_0110", 4'b0110, cc(0, 0, 0, 0), 1'b0, 1'b1, 2'b01, 2'd0, 2'd0);
    run_case("full_col0", 4'b0001, cc(4, 0, 0, 0), 1'b0, 1'b1, 2'b10, 2'd0, 2'd0);
    run_case("game_over", 4'b0001, cc(0, 0, 0, 0), 1'b1, 1'b1, 2'b11, 2'd0, 2'd0);
    run_case("onehot_zero", 4'b0000, cc(0, 0, 0, 0), 1'b0, 1'b1, 2'b01, 2'd0, 2'd0);
    run_case("full_col1_7", 4'b0010, cc(0, 7, 0, 0), 1'b0, 1'b1, 2'b10, 2'd0, 2'd0);
    run_case("over_beats_onehot", 4'b0110, cc(0, 0, 0, 0), 1'b1, 1'b1, 2'b11, 2'd0, 2'd0);
    run_case("onehot_beats_full", 4'b0011, cc(4, 4, 0, 0), 1'b0, 1'b1, 2'b01, 2'd0, 2'd0);
    run_case("row_top", 4'b1000, cc(0, 0, 0, 3), 1'b0, 1'b0, 2'b00, 2'd3, 2'd3);
    check("code_held_after_move", {30'b0, reject_code}, {30'b0, 2'b01});
    run_case("row_zero", 4'b0001, cc(0, 5, 5, 5), 1'b0, 1'b0, 2'b00, 2'd0, 2'd0);

    // Held button: one move for a 200-cycle hold, then a fresh press moves again
    sw = 4'b0100;
    col_counts = cc(0, 0, 2, 0);
    move_ready = 1'b1;
    m0 = n_moves;
    sb.push_back('{1'b0, 2'd2, 2'd2, 2'd0});
    btn_raw = 1'b1;
    repeat (200) step();
    check("held_one_move", n_moves - m0, 1);
    check("held_busy", {31'b0, busy}, 1);
    btn_raw = 1'b0;
    wait_idle(100);
    run_case("second_press", 4'b0100, cc(0, 0, 3, 0), 1'b0, 1'b0, 2'b00, 2'd2, 2'd3);

    // Reset mid-offer drops the offer at once; the bench forgets that move
    sw = 4'b0001;
    col_counts = cc(1, 0, 0, 0);
    move_ready = 1'b0;
    sb.push_back('{1'b0, 2'd0, 2'd1, 2'd0});
    btn_raw = 1'b1;
    wait_valid(30);
    step();
    reset = 1'b0;
    #1;
    check("rst_mid_valid", {31'b0, move_valid}, 0);
    check("rst_mid_busy", {31'b0, busy}, 0);
    sb.delete();
    btn_raw = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    check("post_rst_busy", {31'b0, busy}, 0);
    check("post_rst_code", {30'b0, reject_code}, 0);
    run_case("after_reset", 4'b0001, cc(1, 0, 0, 0), 1'b0, 1'b0, 2'b00, 2'd0, 2'd1);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
